// File: rtl/xadc_drp_reader_if.sv
// rtl/xadc_drp_reader_if.sv - XADC DRP read-port bundle (conversion strobe, request, response)
interface xadc_drp_reader_if;
    logic        eoc_in;
    logic        drdy_in;
    logic [15:0] do_in;
    logic        den_out;
    logic [6:0]  daddr_out;

    modport master (
        input  eoc_in,
        input  drdy_in,
        input  do_in,
        output den_out,
        output daddr_out
    );

    modport slave (
        output eoc_in,
        output drdy_in,
        output do_in,
        input  den_out,
        input  daddr_out
    );
endinterface

// File: rtl/xadc_drp_reader.sv
// rtl/xadc_drp_reader.sv - debounced two-channel XADC DRP sample reader with timeout and drop counter
module xadc_drp_reader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                btn0,
    xadc_drp_reader_if.master   drp,
    output logic [11:0]         sample,
    output logic                sample_valid,
    output logic                sample_chan,
    output logic                timeout_err,
    output logic [7:0]          drop_count
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0] ADDR_VAUX4  = 7'h14;
    localparam logic [6:0] ADDR_VAUX12 = 7'h1C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_sel;
    logic [DB_W-1:0] r_db_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_chan;
    logic            r_den;
    logic [6:0]      r_daddr;
    logic [11:0]     r_sample;
    logic            r_sample_valid;
    logic            r_sample_chan;
    logic            r_timeout_err;
    logic [7:0]      r_drop_count;
    logic            w_unused_lsb;

    assign w_unused_lsb  = ^drp.do_in[3:0];
    assign drp.den_out   = r_den;
    assign drp.daddr_out = r_daddr;
    assign sample        = r_sample;
    assign sample_valid  = r_sample_valid;
    assign sample_chan   = r_sample_chan;
    assign timeout_err   = r_timeout_err;
    assign drop_count    = r_drop_count;

    // Button: two-flop synchronizer, then a stability counter that restarts on any bounce.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sel    <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= btn0;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_sel) begin
                if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_sel    <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= 8'd0;
        end else if (drp.eoc_in && (r_state != S_IDLE) && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    // WAIT lasts at most TIMEOUT_CYCLES cycles; drdy_in on the last one still wins.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_to_cnt       <= '0;
            r_chan         <= 1'b0;
            r_den          <= 1'b0;
            r_daddr        <= ADDR_VAUX4;
            r_sample       <= 12'd0;
            r_sample_valid <= 1'b0;
            r_sample_chan  <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (drp.eoc_in) begin
                        r_chan  <= r_sel;
                        r_den   <= 1'b1;
                        r_daddr <= r_sel ? ADDR_VAUX12 : ADDR_VAUX4;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_den    <= 1'b0;
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (drp.drdy_in) begin
                        r_sample       <= drp.do_in[15:4];
                        r_sample_chan  <= r_chan;
                        r_sample_valid <= 1'b1;
                        r_state        <= S_IDLE;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_den   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_drp_reader.sv
// tb/tb_xadc_drp_reader.sv - randomized self-checking bench for xadc_drp_reader
module tb_xadc_drp_reader;
    localparam int DB = 200;
    localparam int TO = 1000;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        btn0   = 1'b0;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_chan;
    logic        timeout_err;
    logic [7:0]  drop_count;

    xadc_drp_reader_if drp ();

    xadc_drp_reader #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .btn0         (btn0),
        .drp          (drp),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .timeout_err  (timeout_err),
        .drop_count   (drop_count)
    );

    always #5 sysclk = ~sysclk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] m_sample = 12'd0;
    logic        m_chan   = 1'b0;
    int          m_drops  = 0;

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic model_drop();
        if (m_drops < 255) m_drops++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drp.eoc_in = 1'b0; drp.drdy_in = 1'b0; drp.do_in = 16'h0; btn0 = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (drp.den_out !== 1'b0 || drp.daddr_out !== 7'h14) begin
            n_fail++; $display("FAIL reset_drp: den=%0b daddr=%0h want den=0 daddr=14", drp.den_out, drp.daddr_out);
        end
        n_tests++;
        if (sample !== 12'd0 || sample_valid !== 1'b0 || sample_chan !== 1'b0) begin
            n_fail++; $display("FAIL reset_sample: sample=%0h valid=%0b chan=%0b want 0/0/0", sample, sample_valid, sample_chan);
        end
        n_tests++;
        if (timeout_err !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_err: timeout=%0b drops=%0d want 0/0", timeout_err, drop_count);
        end
        rst_n = 1'b1;
        m_sample = 12'd0; m_chan = 1'b0; m_drops = 0;
        tick();
    endtask

    // One full read; delay = idle WAIT cycles before drdy_in. Busy eoc pulses feed the drop model.
    task automatic run_read(input logic exp_chan, input int delay, input logic [15:0] data,
                            input bit eoc_busy, input string name);
        bit bad = 0;
        drp.eoc_in = 1'b1;
        tick();
        drp.eoc_in = 1'b0;
        n_tests++;
        if (drp.den_out !== 1'b1 || drp.daddr_out !== (exp_chan ? 7'h1C : 7'h14)) begin
            n_fail++; $display("FAIL %s_req: den=%0b daddr=%0h want den=1 daddr=%0h", name,
                               drp.den_out, drp.daddr_out, exp_chan ? 7'h1C : 7'h14);
        end
        tick();
        for (int i = 0; i < delay; i++) begin
            if (drp.den_out !== 1'b0 || sample_valid !== 1'b0 || timeout_err !== 1'b0) bad = 1;
            drp.eoc_in = eoc_busy ? 1'($urandom % 2) : 1'b0;
            if (drp.eoc_in) model_drop();
            tick();
        end
        if (drp.den_out !== 1'b0 || sample_valid !== 1'b0) bad = 1;
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL %s_wait: unexpected den/strobe during WAIT, got 1 want 0", name);
        end
        drp.drdy_in = 1'b1;
        drp.do_in   = data;
        drp.eoc_in  = eoc_busy ? 1'b1 : 1'b0;
        if (drp.eoc_in) model_drop();
        tick();
        drp.drdy_in = 1'b0; drp.eoc_in = 1'b0; drp.do_in = 16'($urandom);
        m_sample = data[15:4];
        m_chan   = exp_chan;
        n_tests++;
        if (sample_valid !== 1'b1 || sample !== m_sample || sample_chan !== m_chan || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL %s_capture: valid=%0b sample=%0h chan=%0b to=%0b want 1/%0h/%0b/0", name,
                               sample_valid, sample, sample_chan, timeout_err, m_sample, m_chan);
        end
        tick();
        n_tests++;
        if (sample_valid !== 1'b0 || drp.den_out !== 1'b0 || drop_count !== 8'(m_drops)) begin
            n_fail++; $display("FAIL %s_after: valid=%0b den=%0b drops=%0d want 0/0/%0d", name,
                               sample_valid, drp.den_out, drop_count, m_drops);
        end
    endtask

    task automatic test_basic();
        btn0 = 1'b0;
        run_read(1'b0, 1, 16'hABC5, 1'b0, "basic");
    endtask

    task automatic test_random_reads();
        for (int k = 0; k < 8; k++) begin
            logic c;
            c = 1'($urandom % 2);
            btn0 = c;
            repeat (DB + 3) tick();
            run_read(c, $urandom_range(0, 40), 16'($urandom), 1'b1, "rand");
        end
        btn0 = 1'b0;
        repeat (DB + 3) tick();
    endtask

    task automatic test_debounce();
        btn0 = 1'b1;
        repeat (DB + 3) tick();
        run_read(1'b1, 2, 16'h5A3F, 1'b0, "db_held");
        btn0 = 1'b0;
        repeat (DB + 3) tick();
        run_read(1'b0, 0, 16'h1234, 1'b0, "db_back");
        btn0 = 1'b1;
        repeat (DB - 3) tick();
        btn0 = 1'b0;
        repeat (5) tick();
        run_read(1'b0, 0, 16'h7777, 1'b0, "db_short");
        for (int k = 0; k < 9; k++) begin
            btn0 = ~btn0;
            repeat (100) tick();
        end
        run_read(1'b0, 3, 16'hFEDC, 1'b0, "db_bounce");
        btn0 = 1'b0;
        repeat (DB + 3) tick();
    endtask

    task automatic test_timeout();
        int hit = -1;
        int pulses = 0;
        int strobes = 0;
        drp.eoc_in = 1'b1;
        tick();
        drp.eoc_in = 1'b0;
        tick();
        for (int i = 0; i <= TO + 5; i++) begin
            if (timeout_err === 1'b1) begin
                pulses++;
                if (hit < 0) hit = i;
            end
            if (sample_valid === 1'b1) strobes++;
            tick();
        end
        n_tests++;
        if (hit != TO || pulses != 1) begin
            n_fail++; $display("FAIL timeout_pulse: at=%0d pulses=%0d want at=%0d pulses=1", hit, pulses, TO);
        end
        n_tests++;
        if (strobes != 0 || sample !== m_sample || sample_chan !== m_chan) begin
            n_fail++; $display("FAIL timeout_hold: strobes=%0d sample=%0h chan=%0b want 0/%0h/%0b",
                               strobes, sample, sample_chan, m_sample, m_chan);
        end
        run_read(1'b0, 4, 16'h0F0F, 1'b0, "post_to");
    endtask

    task automatic test_coincident();
        logic [15:0] d;
        d = 16'($urandom);
        drp.eoc_in = 1'b1;
        tick();
        drp.eoc_in = 1'b0;
        tick();
        repeat (TO - 1) tick();
        drp.drdy_in = 1'b1;
        drp.do_in   = d;
        tick();
        drp.drdy_in = 1'b0;
        m_sample = d[15:4];
        m_chan   = 1'b0;
        n_tests++;
        if (sample_valid !== 1'b1 || timeout_err !== 1'b0 || sample !== m_sample) begin
            n_fail++; $display("FAIL coincident: valid=%0b to=%0b sample=%0h want 1/0/%0h",
                               sample_valid, timeout_err, sample, m_sample);
        end
        tick();
        n_tests++;
        if (timeout_err !== 1'b0 || sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL coincident_after: to=%0b valid=%0b want 0/0", timeout_err, sample_valid);
        end
    endtask

    task automatic test_drops();
        int done = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_drops = 0; m_sample = 12'd0; m_chan = 1'b0;
        tick();
        drp.eoc_in = 1'b1;
        tick();
        for (int i = 1; i <= 300; i++) begin
            model_drop();
            tick();
            if (i == 100) begin
                n_tests++;
                if (drop_count !== 8'(m_drops)) begin
                    n_fail++; $display("FAIL drops_100: got %0d want %0d", drop_count, m_drops);
                end
            end
        end
        drp.eoc_in = 1'b0;
        tick();
        n_tests++;
        if (drop_count !== 8'd255 || m_drops != 255) begin
            n_fail++; $display("FAIL drops_sat: got %0d want 255", drop_count);
        end
        for (int i = 0; i < TO + 10 && done == 0; i++) begin
            if (timeout_err === 1'b1) done = 1;
            tick();
        end
        n_tests++;
        if (done != 1 || drop_count !== 8'd255) begin
            n_fail++; $display("FAIL drops_end: timeout_seen=%0d drops=%0d want 1/255", done, drop_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit strobe = 0;
        run_read(1'b0, 0, 16'h9995, 1'b0, "pre_rst");
        drp.eoc_in = 1'b1;
        tick();
        drp.eoc_in = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (drop_count !== 8'd0 || sample !== 12'd0 || drp.den_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: drops=%0d sample=%0h den=%0b want 0/0/0", drop_count, sample, drp.den_out);
        end
        m_drops = 0; m_sample = 12'd0; m_chan = 1'b0;
        tick();
        rst_n = 1'b1;
        drp.drdy_in = 1'b1;
        drp.do_in   = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sample_valid !== 1'b0 || timeout_err !== 1'b0) strobe = 1;
        end
        drp.drdy_in = 1'b0;
        n_tests++;
        if (strobe || sample !== 12'd0 || sample_chan !== 1'b0 || drp.daddr_out !== 7'h14 ||
            drp.den_out !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL rst_mid_wait: strobe=%0b sample=%0h chan=%0b daddr=%0h den=%0b drops=%0d want 0/0/0/14/0/0",
                               strobe, sample, sample_chan, drp.daddr_out, drp.den_out, drop_count);
        end
        run_read(1'b0, 2, 16'h4321, 1'b0, "post_rst");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drp.eoc_in = 1'b0; drp.drdy_in = 1'b0; drp.do_in = 16'h0;
        test_reset();
        test_basic();
        test_random_reads();
        test_debounce();
        test_timeout();
        test_coincident();
        test_drops();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xadc_drp_reader.md
XADC_DRP_READER -- requirements
Module: xadc_drp_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of stable sysclk cycles btn0 must hold before the channel select changes (10 ms at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for drdy_in after a read request.
REQ-003 SHALL have port sysclk, input, 1 bit: the single clock, 100 MHz, shared with the XADC DRP.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port btn0, input, 1 bit: asynchronous channel-select button; 1 selects VAUX12, 0 selects VAUX4.
REQ-006 SHALL have port eoc_in, input, 1 bit: XADC end-of-conversion pulse.
REQ-007 SHALL have port drdy_in, input, 1 bit: XADC DRP data-ready.
REQ-008 SHALL have port do_in, input, 16 bits: XADC DRP read data.
REQ-009 SHALL have port den_out, output, 1 bit: DRP enable (read request).
REQ-010 SHALL have port daddr_out, output, 7 bits: DRP address.
REQ-011 SHALL have port sample, output, 12 bits: last captured conversion result.
REQ-012 SHALL have port sample_valid, output, 1 bit: one-cycle strobe marking a new sample.
REQ-013 SHALL have port sample_chan, output, 1 bit: channel of sample; 0 = VAUX4, 1 = VAUX12.
REQ-014 SHALL have port timeout_err, output, 1 bit: one-cycle strobe on DRP timeout.
REQ-015 SHALL have port drop_count, output, 8 bits: saturating count of eoc_in pulses ignored while busy.

Function
REQ-016 SHALL pass btn0 through a two-flop synchronizer before any other use.
REQ-017 SHALL update the debounced select only after the synchronized btn0 has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count at 0.
REQ-018 SHALL implement the states IDLE, REQ and WAIT.
REQ-019 In IDLE with eoc_in=1, SHALL latch the debounced select into the channel register and enter REQ on the next cycle.
REQ-020 In REQ, SHALL drive den_out=1 for exactly one cycle, with daddr_out = 7'h14 if the channel register is 0 or 7'h1C if it is 1, then enter WAIT.
REQ-021 daddr_out SHALL hold its value from REQ until the next REQ; den_out SHALL be 0 in every state except REQ.
REQ-022 In WAIT with drdy_in=1, SHALL register sample = do_in[15:4] and sample_chan = the channel register, pulse sample_valid on the following cycle, and return to IDLE.
REQ-023 Latency: eoc_in at cycle 0 gives den_out at cycle 1; drdy_in at cycle k gives sample_valid at cycle k+1.
REQ-024 In WAIT, SHALL count cycles from 0; after TIMEOUT_CYCLES cycles without drdy_in, SHALL pulse timeout_err for one cycle, return to IDLE, and leave sample and sample_chan unchanged.
REQ-025 If drdy_in=1 in the same cycle the count reaches TIMEOUT_CYCLES, the sample SHALL be captured and no timeout_err SHALL occur.
REQ-026 drdy_in SHALL be ignored outside WAIT.
REQ-027 eoc_in=1 in REQ or WAIT SHALL increment drop_count, saturating at 255 with no wrap.
REQ-028 eoc_in in the same cycle WAIT returns to IDLE SHALL be counted as dropped and SHALL NOT start a read.
REQ-029 A select change during REQ or WAIT SHALL NOT affect the in-flight read.

Reset
REQ-030 Asserting rst_n=0 SHALL force IDLE immediately, including mid-transaction.
REQ-031 The reset values SHALL be: den_out=0, daddr_out=7'h14, sample=0, sample_valid=0, sample_chan=0, timeout_err=0, drop_count=0, debounced select=0, and all counters=0.
REQ-032 After release, the first read SHALL require a fresh eoc_in, and no strobe SHALL be emitted from any pre-reset transaction.

Verification
REQ-033 btn0=0; eoc_in pulses at cycle 0; drdy_in=1 with do_in=16'hABC5 at cycle 3 -> den_out=1 at cycle 1 with daddr=7'h14; sample=12'hABC, sample_chan=0, sample_valid=1 at cycle 4.
REQ-034 btn0=1 held for DEBOUNCE_CYCLES+3 cycles, then a read -> daddr_out=7'h1C, sample_chan=1. btn0 toggling every 100 cycles -> select stays 0.
REQ-035 eoc_in, then no drdy_in -> timeout_err pulses exactly TIMEOUT_CYCLES cycles after entering WAIT; sample unchanged; the next eoc_in is accepted normally.
REQ-036 300 eoc_in pulses while WAIT is held by a stalled drdy_in (TIMEOUT_CYCLES=1000) -> drop_count=255, no wrap.
REQ-037 rst_n=0 asserted in WAIT; drdy_in arrives after release -> no sample_valid; all outputs at their reset values.
REQ-038 drdy_in coincident with the timeout cycle -> sample_valid=1, timeout_err=0.
